// File: rtl/snake_move_if.sv
// snake_move_if -- button inputs and game-status outputs of the snake move
// controller, bundled so the button logic, renderer and wall generator share
// one connection.
//   btn_up/down/left/right : single-cycle debounced direction pulses
//   btn_start              : single-cycle start/pause/restart pulse
//   head_x, head_y         : head square top-left corner (pixels)
//   dir                    : committed direction (0 up, 1 down, 2 left, 3 right)
//   state                  : 0 IDLE, 1 PLAY, 2 PAUSE, 3 DEAD
//   move_tick              : one-cycle pulse with each new head position
//   game_over              : high while in DEAD
//   score                  : successful moves, saturating at 255
// The master modport is the button/consumer side; the slave modport is the
// controller itself.
interface snake_move_if;
    logic       btn_up;
    logic       btn_down;
    logic       btn_left;
    logic       btn_right;
    logic       btn_start;
    logic [9:0] head_x;
    logic [9:0] head_y;
    logic [1:0] dir;
    logic [1:0] state;
    logic       move_tick;
    logic       game_over;
    logic [7:0] score;

    modport master (
        output btn_up, btn_down, btn_left, btn_right, btn_start,
        input  head_x, head_y, dir, state, move_tick, game_over, score
    );

    modport slave (
        input  btn_up, btn_down, btn_left, btn_right, btn_start,
        output head_x, head_y, dir, state, move_tick, game_over, score
    );
endinterface

// File: rtl/snake_move_ctrl.sv
// snake_move_ctrl -- game sequencer for the VGA snake game. Runs the
// IDLE/PLAY/PAUSE/DEAD machine, divides clk down to the move tick, owns the
// head position and direction, and kills the game when the next head square
// would overlap the wall frame.
// Ports:
//   clk   : system/pixel clock
//   reset : asynchronous, active-high
//   bus   : snake_move_if.slave (buttons in, head/dir/state/tick/score out)
module snake_move_ctrl #(
    parameter int TICK_DIV  = 5_000_000,
    parameter int STEP      = 10,
    parameter int HEAD_SIZE = 10,
    parameter int START_X   = 320,
    parameter int START_Y   = 240,
    parameter int WALL_LO   = 31,
    parameter int WALL_X_HI = 610,
    parameter int WALL_Y_HI = 450
) (
    input  logic        clk,
    input  logic        reset,
    snake_move_if.slave bus
);

    localparam int CNT_W = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [10:0]      STEP_W    = 11'(STEP);
    localparam logic [10:0]      SIZE_M1_W = 11'(HEAD_SIZE - 1);
    localparam logic [10:0]      LO_W      = 11'(WALL_LO);
    localparam logic [10:0]      X_HI_W    = 11'(WALL_X_HI);
    localparam logic [10:0]      Y_HI_W    = 11'(WALL_Y_HI);
    localparam logic [9:0]       START_X_W = 10'(START_X);
    localparam logic [9:0]       START_Y_W = 10'(START_Y);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PLAY  = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DEAD  = 2'd3
    } state_t;

    state_t         state_r;
    logic [9:0]     head_x_r;
    logic [9:0]     head_y_r;
    logic [1:0]     dir_r;
    logic [1:0]     pending_dir_r;
    logic [CNT_W-1:0] cnt_r;
    logic [7:0]     score_r;
    logic           move_tick_r;
    logic           game_over_r;

    logic           press_valid_s;
    logic [1:0]     press_dir_s;
    logic           accept_s;
    logic [10:0]    nx_s;
    logic [10:0]    ny_s;
    logic           collide_s;

    // True when a head square at (x, y) overlaps the wall frame. The sums wrap
    // in 11 bits, which is wide enough for every reachable head position.
    function automatic logic hits_wall(input logic [10:0] x, input logic [10:0] y);
        hits_wall = (x < LO_W) || ((x + SIZE_M1_W) >= X_HI_W) ||
                    (y < LO_W) || ((y + SIZE_M1_W) >= Y_HI_W);
    endfunction

    // Priority pick among simultaneous direction buttons: up > down > left > right.
    always_comb begin
        press_valid_s = 1'b0;
        press_dir_s   = 2'd3;
        if (bus.btn_up) begin
            press_valid_s = 1'b1;
            press_dir_s   = 2'd0;
        end else if (bus.btn_down) begin
            press_valid_s = 1'b1;
            press_dir_s   = 2'd1;
        end else if (bus.btn_left) begin
            press_valid_s = 1'b1;
            press_dir_s   = 2'd2;
        end else if (bus.btn_right) begin
            press_valid_s = 1'b1;
            press_dir_s   = 2'd3;
        end else begin
            press_valid_s = 1'b0;
            press_dir_s   = 2'd3;
        end
    end

    // Opposite directions differ only in bit 0, so a reversal is dir ^ 1; a
    // rejected winner also blocks the lower-priority buttons.
    assign accept_s = press_valid_s && (press_dir_s != (dir_r ^ 2'd1));

    // Candidate next head position along the pending direction.
    always_comb begin
        nx_s = {1'b0, head_x_r};
        ny_s = {1'b0, head_y_r};
        case (pending_dir_r)
            2'd0:    ny_s = {1'b0, head_y_r} - STEP_W;
            2'd1:    ny_s = {1'b0, head_y_r} + STEP_W;
            2'd2:    nx_s = {1'b0, head_x_r} - STEP_W;
            2'd3:    nx_s = {1'b0, head_x_r} + STEP_W;
            default: begin
                nx_s = {1'b0, head_x_r};
                ny_s = {1'b0, head_y_r};
            end
        endcase
    end

    assign collide_s = hits_wall(nx_s, ny_s);

    // Game state machine, tick divider, head/direction/score registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r       <= ST_IDLE;
            head_x_r      <= START_X_W;
            head_y_r      <= START_Y_W;
            dir_r         <= 2'd3;
            pending_dir_r <= 2'd3;
            cnt_r         <= '0;
            score_r       <= 8'd0;
            move_tick_r   <= 1'b0;
            game_over_r   <= 1'b0;
        end else begin
            move_tick_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) pending_dir_r <= press_dir_s;
                    if (bus.btn_start) begin
                        state_r <= ST_PLAY;
                        cnt_r   <= '0;
                    end
                end
                ST_PLAY: begin
                    if (accept_s) pending_dir_r <= press_dir_s;
                    // Pause beats a coincident terminal count; the counter
                    // holds so the move happens right after resume.
                    if (bus.btn_start) begin
                        state_r <= ST_PAUSE;
                    end else if (cnt_r == CNT_LAST) begin
                        cnt_r <= '0;
                        if (collide_s) begin
                            state_r     <= ST_DEAD;
                            game_over_r <= 1'b1;
                        end else begin
                            head_x_r    <= nx_s[9:0];
                            head_y_r    <= ny_s[9:0];
                            dir_r       <= pending_dir_r;
                            move_tick_r <= 1'b1;
                            if (score_r != 8'd255) score_r <= score_r + 8'd1;
                        end
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                ST_PAUSE: begin
                    if (accept_s) pending_dir_r <= press_dir_s;
                    if (bus.btn_start) state_r <= ST_PLAY;
                end
                ST_DEAD: begin
                    if (bus.btn_start) begin
                        state_r       <= ST_IDLE;
                        head_x_r      <= START_X_W;
                        head_y_r      <= START_Y_W;
                        dir_r         <= 2'd3;
                        pending_dir_r <= 2'd3;
                        cnt_r         <= '0;
                        score_r       <= 8'd0;
                        game_over_r   <= 1'b0;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    game_over_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.head_x    = head_x_r;
    assign bus.head_y    = head_y_r;
    assign bus.dir       = dir_r;
    assign bus.state     = state_r;
    assign bus.move_tick = move_tick_r;
    assign bus.game_over = game_over_r;
    assign bus.score     = score_r;

endmodule

// File: tb/tb_snake_move_ctrl.sv
// tb_snake_move_ctrl -- self-checking bench for snake_move_ctrl with a short
// move period. Every cycle is compared against a behavioural game model; a
// hand-written vector table and directed sequences add fixed expectations.
module tb_snake_move_ctrl;

    localparam int TD = 4;
    localparam logic [33:0] RESET_BUNDLE = {2'd0, 10'd320, 10'd240, 2'd3, 8'd0, 1'b0, 1'b0};

    logic clk;
    logic reset;
    snake_move_if bus ();

    snake_move_ctrl #(.TICK_DIV(TD)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    // Behavioural model: plain integers, directions as unit steps.
    int m_state, m_hx, m_hy, m_dir, m_pend, m_cnt, m_score;
    bit m_tick;

    typedef struct {
        bit         u, d, l, r, s;
        logic [1:0] st;
        logic [9:0] hx, hy;
        logic [1:0] dr;
        logic [7:0] sc;
        logic       tk;
    } vec_t;
    vec_t tbl [17];

    function automatic vec_t mk(bit u, bit d, bit l, bit r, bit s, int st, int hx, int hy,
                                int dr, int sc, bit tk);
        vec_t v;
        v.u = u; v.d = d; v.l = l; v.r = r; v.s = s;
        v.st = 2'(st); v.hx = 10'(hx); v.hy = 10'(hy);
        v.dr = 2'(dr); v.sc = 8'(sc); v.tk = tk;
        return v;
    endfunction

    function automatic void check(string name, logic [63:0] got, logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, got, exp);
        end
    endfunction

    function automatic void model_reset();
        m_state = 0; m_hx = 320; m_hy = 240; m_dir = 3; m_pend = 3;
        m_cnt = 0; m_score = 0; m_tick = 0;
    endfunction

    function automatic bit is_reversal(int a, int b);
        return (a == 0 && b == 1) || (a == 1 && b == 0) ||
               (a == 2 && b == 3) || (a == 3 && b == 2);
    endfunction

    function automatic void model_step(bit u, bit d, bit l, bit r, bit s);
        int  want;
        bit  take;
        int  nx, ny;
        want = u ? 0 : d ? 1 : l ? 2 : 3;
        take = (u | d | l | r) && (m_state != 3) && !is_reversal(want, m_dir);
        m_tick = 0;
        case (m_state)
            0: if (s) begin m_state = 1; m_cnt = 0; end
            1: begin
                if (s) m_state = 2;
                else if (m_cnt == TD - 1) begin
                    m_cnt = 0;
                    nx = m_hx + ((m_pend == 2) ? -10 : (m_pend == 3) ? 10 : 0);
                    ny = m_hy + ((m_pend == 0) ? -10 : (m_pend == 1) ? 10 : 0);
                    if (nx < 31 || nx + 9 >= 610 || ny < 31 || ny + 9 >= 450) m_state = 3;
                    else begin
                        m_hx = nx; m_hy = ny; m_dir = m_pend; m_tick = 1;
                        if (m_score < 255) m_score++;
                    end
                end else m_cnt++;
            end
            2: if (s) m_state = 1;
            default: if (s) begin model_reset(); take = 0; end
        endcase
        if (take) m_pend = want;
    endfunction

    function automatic logic [33:0] model_bundle();
        return {2'(m_state), 10'(m_hx), 10'(m_hy), 2'(m_dir), 8'(m_score), m_tick, (m_state == 3)};
    endfunction

    function automatic logic [33:0] dut_bundle();
        return {bus.state, bus.head_x, bus.head_y, bus.dir, bus.score, bus.move_tick, bus.game_over};
    endfunction

    function automatic logic [33:0] vec_bundle(vec_t v);
        return {v.st, v.hx, v.hy, v.dr, v.sc, v.tk, (v.st == 2'd3)};
    endfunction

    // One clock: drive buttons at the falling edge, sample 1 ns after the rising edge.
    task automatic step(input bit u, input bit d, input bit l, input bit r, input bit s);
        @(negedge clk);
        bus.btn_up = u; bus.btn_down = d; bus.btn_left = l; bus.btn_right = r; bus.btn_start = s;
        @(posedge clk);
        model_step(u, d, l, r, s);
        #1;
        check("cycle_vs_model", dut_bundle(), model_bundle());
        bus.btn_up = 1'b0; bus.btn_down = 1'b0; bus.btn_left = 1'b0;
        bus.btn_right = 1'b0; bus.btn_start = 1'b0;
    endtask

    // Reset between clock edges; outputs must clear with no edge.
    task automatic async_reset(input string name);
        reset = 1'b1;
        model_reset();
        #1;
        check(name, dut_bundle(), RESET_BUNDLE);
        @(negedge clk);
        reset = 1'b0;
    endtask

    int ticks;

    initial begin
        reset = 1'b1;
        bus.btn_up = 1'b0; bus.btn_down = 1'b0; bus.btn_left = 1'b0;
        bus.btn_right = 1'b0; bus.btn_start = 1'b0;
        model_reset();

        tbl[0]  = mk(0,0,0,0,1, 1,320,240,3,0,0);
        tbl[1]  = mk(0,0,0,0,0, 1,320,240,3,0,0);
        tbl[2]  = mk(0,0,0,0,0, 1,320,240,3,0,0);
        tbl[3]  = mk(0,0,0,0,0, 1,320,240,3,0,0);
        tbl[4]  = mk(0,0,0,0,0, 1,330,240,3,1,1);
        tbl[5]  = mk(1,0,0,0,0, 1,330,240,3,1,0);
        tbl[6]  = mk(0,0,0,0,0, 1,330,240,3,1,0);
        tbl[7]  = mk(0,0,0,0,0, 1,330,240,3,1,0);
        tbl[8]  = mk(0,0,0,0,0, 1,330,230,0,2,1);
        tbl[9]  = mk(0,1,0,0,0, 1,330,230,0,2,0);
        tbl[10] = mk(0,0,0,0,0, 1,330,230,0,2,0);
        tbl[11] = mk(0,0,0,0,0, 1,330,230,0,2,0);
        tbl[12] = mk(0,0,0,0,0, 1,330,220,0,3,1);
        tbl[13] = mk(0,1,1,0,0, 1,330,220,0,3,0);
        tbl[14] = mk(0,0,0,0,0, 1,330,220,0,3,0);
        tbl[15] = mk(0,0,0,0,0, 1,330,220,0,3,0);
        tbl[16] = mk(0,0,0,0,0, 1,330,210,0,4,1);

        repeat (2) @(negedge clk);
        check("reset_values", dut_bundle(), RESET_BUNDLE);
        reset = 1'b0;

        for (int i = 0; i < 17; i++) begin
            step(tbl[i].u, tbl[i].d, tbl[i].l, tbl[i].r, tbl[i].s);
            check($sformatf("table[%0d]", i), dut_bundle(), vec_bundle(tbl[i]));
        end
        async_reset("reset_during_tick");

        // Straight run right into the wall.
        step(0,0,0,0,1);
        ticks = 0;
        for (int i = 0; i < 116; i++) begin
            step(0,0,0,0,0);
            if (bus.move_tick) ticks++;
        end
        check("right_ticks", 64'(ticks), 64'd28);
        check("right_state", bus.state, 2'd3);
        check("right_game_over", bus.game_over, 1'b1);
        check("right_head_x", bus.head_x, 10'd600);
        check("right_head_y", bus.head_y, 10'd240);
        check("right_score", bus.score, 8'd28);

        step(0,0,0,0,1);
        check("restart_values", dut_bundle(), RESET_BUNDLE);

        // Run up into the top wall.
        step(0,0,0,0,1);
        step(1,0,0,0,0);
        for (int i = 0; i < 83; i++) step(0,0,0,0,0);
        check("up_state", bus.state, 2'd3);
        check("up_head_y", bus.head_y, 10'd40);
        check("up_head_x", bus.head_x, 10'd320);
        check("up_score", bus.score, 8'd20);
        step(0,0,0,0,1);

        // Reversal ignored, later press wins.
        step(0,0,0,0,1);
        step(0,0,1,0,0);
        step(0,1,0,0,0);
        step(0,0,0,0,0);
        step(0,0,0,0,0);
        check("turn_tick", bus.move_tick, 1'b1);
        check("turn_head", {bus.head_x, bus.head_y}, {10'd320, 10'd250});
        check("turn_dir", bus.dir, 2'd1);
        async_reset("reset_mid_play");

        // Simultaneous up and right: up wins.
        step(0,0,0,0,1);
        step(1,0,0,1,0);
        step(0,0,0,0,0);
        step(0,0,0,0,0);
        step(0,0,0,0,0);
        check("multi_head", {bus.head_x, bus.head_y}, {10'd320, 10'd230});
        check("multi_dir", bus.dir, 2'd0);
        async_reset("reset_after_multi");

        // Pause at count 2, hold, resume.
        step(0,0,0,0,1);
        step(0,0,0,0,0);
        step(0,0,0,0,0);
        step(0,0,0,0,1);
        check("pause_state", bus.state, 2'd2);
        ticks = 0;
        for (int i = 0; i < 100; i++) begin
            step(0,0,0,0,0);
            if (bus.move_tick) ticks++;
        end
        check("pause_no_ticks", 64'(ticks), 64'd0);
        check("pause_head", {bus.head_x, bus.head_y}, {10'd320, 10'd240});
        step(0,0,0,0,1);
        check("resume_state", bus.state, 2'd1);
        step(0,0,0,0,0);
        check("resume_plus1_tick", bus.move_tick, 1'b0);
        step(0,0,0,0,0);
        check("resume_plus2_tick", bus.move_tick, 1'b1);
        check("resume_head_x", bus.head_x, 10'd330);

        // Pause coincident with terminal count.
        step(0,0,0,0,0);
        step(0,0,0,0,0);
        step(0,0,0,0,0);
        step(0,0,0,0,1);
        check("tc_pause_state", bus.state, 2'd2);
        check("tc_pause_no_tick", bus.move_tick, 1'b0);
        check("tc_pause_head_x", bus.head_x, 10'd330);
        step(0,0,0,0,1);
        step(0,0,0,0,0);
        check("tc_resume_tick", bus.move_tick, 1'b1);
        check("tc_resume_head_x", bus.head_x, 10'd340);
        async_reset("reset_in_play2");

        // Random button traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
                 $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
                 $urandom_range(0, 39) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/snake_move_ctrl.md
# snake_move_ctrl

Game-sequencing controller for the VGA snake game. Runs the IDLE/PLAY/PAUSE/DEAD state machine and generates the periodic move tick. Owns the snake head position and direction, and checks the head against the fixed wall frame: x < 31, x ≥ 610, y < 31, y ≥ 450 on the 640×480 raster. The renderer and the wall generator consume its outputs; the debounced button logic drives its inputs.

## Interface
- TICK_DIV, 5_000_000: clk cycles per move in PLAY; legal range is 2 or more.
- STEP, 10: pixels moved per tick.
- HEAD_SIZE, 10: edge length of the head square in pixels.
- START_X, 320 / START_Y, 240: head top-left corner after reset or restart.
- WALL_LO, 31: first playable x and y coordinate.
- WALL_X_HI, 610: first wall column on the right.
- WALL_Y_HI, 450: first wall row at the bottom.
- clk  in  1  system/pixel clock.
- reset  in  1  asynchronous, active-high; all state returns to its reset value immediately.
- btn_up, btn_down, btn_left, btn_right  in  1 each  single-cycle debounced pulses.
- btn_start  in  1  single-cycle pulse.
- head_x, head_y  out  10 each  head top-left corner, registered.
- dir  out  2  committed direction: 0 up, 1 down, 2 left, 3 right.
- state  out  2  0 IDLE, 1 PLAY, 2 PAUSE, 3 DEAD.
- move_tick  out  1  one-cycle pulse, asserted in the same cycle the new head position first appears.
- game_over  out  1  high exactly when state = DEAD.
- score  out  8  successful moves since the game started; saturates at 255.

## Operation
- Reset values:
  - state = IDLE
  - head = (START_X, START_Y)
  - dir = 3 (right); pending_dir = 3
  - tick counter = 0
  - score = 0
  - move_tick = 0
  - game_over = 0
- IDLE:
  - btn_start → PLAY with tick counter = 0.
  - Direction buttons update pending_dir, subject to the same rules as in PLAY.
- PLAY:
  - Tick counter runs 0..TICK_DIV-1.
  - At terminal count, compute the next head = head ± STEP along pending_dir.
  - The next head collides if any of these hold: nx < WALL_LO, nx+HEAD_SIZE-1 ≥ WALL_X_HI, ny < WALL_LO, ny+HEAD_SIZE-1 ≥ WALL_Y_HI.
  - Compare in 11-bit arithmetic so subtraction underflow counts as a collision.
  - No collision: head ← next, dir ← pending_dir, score increments (saturating), move_tick pulses.
  - Collision: state → DEAD, head and dir unchanged, score unchanged, no move_tick.
  - btn_start → PAUSE.
- PAUSE:
  - Tick counter frozen; head, dir and score held.
  - btn_start → PLAY; counting resumes from the held count.
  - Direction buttons still update pending_dir.
- DEAD:
  - Everything frozen; direction buttons ignored.
  - btn_start → IDLE, reloading head, dir, pending_dir, score and counter to their reset values.
- Direction rules:
  - A button whose direction is opposite to the committed dir is ignored.
  - If several buttons arrive in one cycle, only one is taken, by priority up > down > left > right. A winner that is a reversal is ignored; the lower-priority buttons are not considered.
  - Only the last accepted press before a tick takes effect.

## Timing
- Move period in PLAY: exactly TICK_DIV cycles. The first move_tick comes TICK_DIV cycles after the cycle in which btn_start is sampled in IDLE.
- head, dir, score and move_tick all update on the same clk edge.
- The collision transition to DEAD is registered on that same edge, so game_over rises TICK_DIV cycles after the previous tick.
- Simultaneous btn_start and terminal count in PLAY: the pause wins. No move happens, and the counter holds at TICK_DIV-1, so the move occurs on the first cycle after resume.
- Direction press in the same cycle as a tick: not used for that tick; it applies to the following one.
- Reset asserted mid-tick or mid-pause: outputs go to their reset values asynchronously, and move_tick must not glitch high.

## Test plan
- TICK_DIV=4, reset, btn_start, no buttons:
  - move_tick every 4 cycles.
  - head_x runs 330, 340, …, 600 (28 moves); head_y stays 240.
  - 29th terminal count → state=3, game_over=1, head_x=600, score=28.
- From start, btn_up once:
  - head_y steps 230…40 (20 moves).
  - 21st tick → DEAD with head_y=40, score=20.
- Dir right, then btn_left, then btn_down in the same tick window:
  - left is ignored as a reversal; the next move goes down (head_y=250); dir=1.
- btn_up and btn_right in the same cycle → up wins; the next move decrements head_y.
- Pause:
  - btn_start at counter=2 → state=2, head frozen for 100 cycles.
  - btn_start again → next move_tick exactly 2 cycles after resume.
  - btn_start coincident with terminal count → PAUSE, no move.
- Restart and reset:
  - In DEAD, btn_start → IDLE, head=(320,240), dir=3, score=0.
  - Async reset mid-PLAY → same values, state=0, with no clock edge required.
